view_sequencer: RTL

Controller that shares the single `forward_view` renderer between two karts in split-screen mode. It sits between the kart physics/state blocks and `forward_view`, and does three things:
- Accepts per-player position and heading updates over valid/ready handshakes into shadow registers.
- Commits them atomically once per frame at the start of vertical blanking.
- Per pixel, drives `forward_view`'s player, opponent, direction and local-hcount inputs for whichever half of the screen is being scanned.

---
 rtl/view_sequencer.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/view_sequencer.sv
// view_sequencer: shares one forward_view renderer between two karts.
//   - Per-player updates arrive over valid/ready into shadow registers.
//   - Shadows are copied to the active registers in a single COMMIT cycle
//     at the start of vertical blanking, so a frame never mixes old and
//     new kart state.
//   - A registered per-pixel mux presents the camera/opponent/heading and
//     half-local hcount for whichever half of the screen is being scanned.
// Build option: define SPLIT_SCREEN_EN to enable the left/right split.
// Without it, the player 0 view covers the full width, and player 1 is only
// shown as the opponent.
module view_sequencer #(
  parameter int H_SPLIT  = 512,
  parameter int H_ACTIVE = 1024,
  parameter int V_ACTIVE = 768,
  parameter int DIR_MOD  = 360
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        p0_valid_in,
  output logic        p0_ready_out,
  input  logic [10:0] p0_x_in,
  input  logic [10:0] p0_y_in,
  input  logic [8:0]  p0_dir_in,
  input  logic        p1_valid_in,
  output logic        p1_ready_out,
  input  logic [10:0] p1_x_in,
  input  logic [10:0] p1_y_in,
  input  logic [8:0]  p1_dir_in,
  output logic [10:0] view_player_x_out,
  output logic [10:0] view_player_y_out,
  output logic [10:0] view_opponent_x_out,
  output logic [10:0] view_opponent_y_out,
  output logic [8:0]  view_direction_out,
  output logic [10:0] view_hcount_out,
  output logic        view_sel_out,
  output logic        frame_commit_out
);

  localparam logic [10:0] LP_H_SPLIT  = 11'(H_SPLIT);
  localparam logic [9:0]  LP_V_ACTIVE = 10'(V_ACTIVE);
  localparam logic [8:0]  LP_DIR_MOD  = 9'(DIR_MOD);

  // A split point outside the active line degenerates to a single view
  // rather than producing a right half that never appears on screen.
  localparam bit LP_SPLIT_OK = (H_SPLIT > 0) && (H_SPLIT < H_ACTIVE);

`ifdef SPLIT_SCREEN_EN
  localparam bit LP_SPLIT_EN = 1'b1;
`else
  localparam bit LP_SPLIT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_BLANK  = 2'd0,
    ST_RENDER = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  state_t r_state;
  logic   r_ready;
  logic   r_commit;

  // Per-player inputs gathered into arrays so both players share one datapath
  logic        w_valid  [2];
  logic [10:0] w_x_in   [2];
  logic [10:0] w_y_in   [2];
  logic [8:0]  w_dir_in [2];

  // Active (committed) state per player, as seen by the pixel mux
  logic [10:0] w_act_x   [2];
  logic [10:0] w_act_y   [2];
  logic [8:0]  w_act_dir [2];

  logic w_frame_start;
  logic w_commit_start;
  logic w_right;
  logic w_cam;
  logic w_opp;

  // Fold an out-of-range heading back into 0..DIR_MOD-1. The input never
  // exceeds 511, so one subtraction is enough for DIR_MOD >= 256.
  function automatic logic [8:0] norm_dir(input logic [8:0] d);
    if (d >= LP_DIR_MOD) begin
      return d - LP_DIR_MOD;
    end
    return d;
  endfunction

  assign w_valid[0]  = p0_valid_in;
  assign w_x_in[0]   = p0_x_in;
  assign w_y_in[0]   = p0_y_in;
  assign w_dir_in[0] = p0_dir_in;
  assign w_valid[1]  = p1_valid_in;
  assign w_x_in[1]   = p1_x_in;
  assign w_y_in[1]   = p1_y_in;
  assign w_dir_in[1] = p1_dir_in;

  assign w_frame_start  = (vcount_in == 10'd0) && (hcount_in == 11'd0);
  assign w_commit_start = (r_state == ST_RENDER) &&
                          (vcount_in == LP_V_ACTIVE) && (hcount_in == 11'd0);

  assign p0_ready_out = r_ready;
  assign p1_ready_out = r_ready;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_player
      logic        w_accept;
      logic [8:0]  w_dir_norm;
      logic [10:0] r_sh_x;
      logic [10:0] r_sh_y;
      logic [8:0]  r_sh_dir;
      logic [10:0] r_act_x;
      logic [10:0] r_act_y;
      logic [8:0]  r_act_dir;

      assign w_accept   = w_valid[gi] && r_ready;
      assign w_dir_norm = norm_dir(w_dir_in[gi]);

      // Shadow capture on every accepted update; the latest one in a frame wins
      always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
          r_sh_x   <= '0;
          r_sh_y   <= '0;
          r_sh_dir <= '0;
        end else if (w_accept) begin
          r_sh_x   <= w_x_in[gi];
          r_sh_y   <= w_y_in[gi];
          r_sh_dir <= w_dir_norm;
        end
      end

      // Atomic copy to active on the edge that enters COMMIT. An update accepted
      // on that same edge bypasses the shadow so it still lands in this frame.
      always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
          r_act_x   <= '0;
          r_act_y   <= '0;
          r_act_dir <= '0;
        end else if (w_commit_start) begin
          if (w_accept) begin
            r_act_x   <= w_x_in[gi];
            r_act_y   <= w_y_in[gi];
            r_act_dir <= w_dir_norm;
          end else begin
            r_act_x   <= r_sh_x;
            r_act_y   <= r_sh_y;
            r_act_dir <= r_sh_dir;
          end
        end
      end

      assign w_act_x[gi]   = r_act_x;
      assign w_act_y[gi]   = r_act_y;
      assign w_act_dir[gi] = r_act_dir;
    end
  endgenerate

  // Frame sequencing FSM with registered ready and commit pulse
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state  <= ST_BLANK;
      r_ready  <= 1'b0;
      r_commit <= 1'b0;
    end else begin
      r_ready  <= 1'b1;
      r_commit <= 1'b0;
      case (r_state)
        ST_BLANK: begin
          if (w_frame_start) begin
            r_state <= ST_RENDER;
          end
        end
        ST_RENDER: begin
          if (w_commit_start) begin
            r_state  <= ST_COMMIT;
            r_commit <= 1'b1;
            r_ready  <= 1'b0;
          end
        end
        ST_COMMIT: begin
          r_state <= ST_BLANK;
        end
        default: begin
          r_state <= ST_BLANK;
        end
      endcase
    end
  end

  assign frame_commit_out = r_commit;

  // Right half (including horizontal blank) belongs to player 1 when split
  assign w_right = LP_SPLIT_EN && LP_SPLIT_OK && (hcount_in >= LP_H_SPLIT);
  assign w_cam   = w_right;
  assign w_opp   = !w_right;

  // Registered per-pixel view mux: one cycle from hcount to all view outputs
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      view_player_x_out   <= '0;
      view_player_y_out   <= '0;
      view_opponent_x_out <= '0;
      view_opponent_y_out <= '0;
      view_direction_out  <= '0;
      view_hcount_out     <= '0;
      view_sel_out        <= 1'b0;
    end else begin
      view_player_x_out   <= w_act_x[w_cam];
      view_player_y_out   <= w_act_y[w_cam];
      view_opponent_x_out <= w_act_x[w_opp];
      view_opponent_y_out <= w_act_y[w_opp];
      view_direction_out  <= w_act_dir[w_cam];
      view_hcount_out     <= w_right ? (hcount_in - LP_H_SPLIT) : hcount_in;
      view_sel_out        <= w_right;
    end
  end

endmodule
